regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequential read-out engine for the 32×32 architectural register file. On a `start` pulse it walks a contiguous address range through one read port, captures each value, and streams `(addr, data)` beats out over a valid/ready handshake. Typical consumers are a debug/trace sink or testbench monitor. It sits beside the core and uses read port 2 while `busy`. It asserts `rf_hold` so the core can stall register writes for a consistent snapshot.

## Interface
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.
- `FIRST`, 0: first address dumped.
- `LAST`, 31: last address dumped. Must satisfy `FIRST <= LAST <= 2^ADDR_W-1`.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- `rf_raddr`  out  ADDR_W  read address to register-file port.
- `rf_rdata`  in  DATA_W  combinational read data from register file, same cycle.
- `rf_hold`  out  1  high while busy; core must suppress register writes.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  sink accepts beat.
- `out_addr`  out  ADDR_W  register index of current beat.
- `out_data`  out  DATA_W  captured register value.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE, FETCH, SEND, DONE. Internal address counter `ptr` (ADDR_W bits).
- IDLE: `ptr` holds FIRST. On `start`=1, go to FETCH.
- FETCH: drive `rf_raddr=ptr`. Register `out_data<=rf_rdata` and `out_addr<=ptr`, then go to SEND.
- SEND: `out_valid`=1.
  - On `out_valid && out_ready`: if `ptr==LAST`, go to DONE. Otherwise `ptr<=ptr+1` and go to FETCH.
  - Otherwise stay in SEND, with `out_addr`/`out_data` held stable.
- DONE: `done`=1 for exactly one cycle. `ptr<=FIRST`, then go to IDLE.
- `rf_raddr` = `ptr` in FETCH and 0 otherwise, so the idle port reads x0.
- `rf_hold` = `busy`.
- End test uses comparison before increment, so LAST=31 never wraps the 5-bit counter.
- A `start` arriving in FETCH, SEND, or DONE is ignored and not queued.
- Address 0 is dumped as-is; the register file supplies 0.
- Values are sampled at FETCH. Later writes, if the core ignores `rf_hold`, are not reflected in a beat already captured.

## Timing
- Reset (`rst`=0 at an edge) forces IDLE and `ptr=FIRST`. It clears `out_valid`, `busy`, `done`, `rf_hold`, `out_addr`, `out_data`, and `rf_raddr` to 0. Reset mid-dump abandons the dump with no `done` pulse.
- `start` sampled high at edge t: FETCH during cycle t+1, and the first `out_valid` in cycle t+2.
- Per-register cost is 2 cycles with `out_ready` held high.
- Full dump: the last beat is accepted in cycle t+2N, with N = LAST−FIRST+1.
- `done` is in cycle t+2N+1, and IDLE resumes at t+2N+2. For defaults, `done` is at t+65.
- A new `start` is accepted in the first IDLE cycle (t+2N+2).
- Back-pressure: each cycle `out_ready`=0 in SEND adds one cycle. There is no combinational path from `out_ready` to `out_valid`.
- `start` and `rst`=0 in the same cycle: reset wins.

## Test plan
- Preload `x_i = 0x100+i` for i=1..31 with `out_ready`=1, then pulse `start`.
  - 32 beats, addr 0..31, with data 0, then 0x101..0x11F.
  - `out_valid` toggles every other cycle.
  - `done` is one pulse 65 cycles after `start`.
  - `busy`/`rf_hold` are high for cycles 1..65.
- Same preload with `out_ready` low for 3 cycles on beat addr 7.
  - `out_addr`=7 and `out_data`=0x107 are held stable for 4 cycles.
  - Total time increases by exactly 3 cycles.
- FIRST=5, LAST=5: exactly one beat (5, x5), with `done` 3 cycles after `start`.
- Pulse `start` again during SEND of beat 10: no effect, beat sequence unchanged, one `done`.
- Drive `rst`=0 during beat 12.
  - Next cycle: all outputs are 0 and `busy`=0, with no `done`.
  - A subsequent `start` dumps from addr 0 correctly.
- Core attempts a write to x3 while `rf_hold`=1 and the bench honours hold: dumped x3 equals the pre-start value.

Source files
------------

// File: rtl/regfile_dump.sv
// regfile_dump: walks register addresses FIRST..LAST through one read port.
// Each value is captured and streamed out as an (addr, data) beat.
// rf_hold stays high for the whole walk so the core can freeze register writes.
//
// Output handshake (out_valid / out_ready): a beat transfers on a rising edge
// where both are high. While out_valid is high and out_ready is low, out_addr
// and out_data stay stable. out_valid never depends combinationally on
// out_ready, and out_valid never drops without a transfer.
module regfile_dump #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int FIRST  = 0,
   parameter int LAST   = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_hold,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SEND  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST);

   state_t            state;
   logic [ADDR_W-1:0] ptr;

   // The FSM and every registered output sit in one block.
   // rf_raddr is loaded on the edge that enters FETCH, so the register file
   // sees ptr throughout the FETCH cycle. Outside FETCH it reads 0.
   // The LAST test happens before the increment, so ptr never wraps.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         ptr       <= FIRST_A;
         rf_raddr  <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               ptr  <= FIRST_A;
               done <= 1'b0;
               if (start) begin
                  state    <= S_FETCH;
                  busy     <= 1'b1;
                  rf_raddr <= FIRST_A;
               end
            end
            S_FETCH: begin
               out_data  <= rf_rdata;
               out_addr  <= ptr;
               out_valid <= 1'b1;
               rf_raddr  <= '0;
               state     <= S_SEND;
            end
            S_SEND: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (ptr == LAST_A) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     ptr      <= ptr + ADDR_W'(1);
                     rf_raddr <= ptr + ADDR_W'(1);
                     state    <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               ptr   <= FIRST_A;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // The hold request mirrors busy, and the state is visible for debug.
   always_comb begin
      rf_hold   = busy;
      dbg_state = state;
   end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: checks regfile_dump against a beat-list and timing model.
// The model is built from the register contents at start time.
// A second instance (FIRST=LAST=5) covers the single-beat range.
module tb_regfile_dump;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int BW = AW + DW;

   // clock / reset block
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // main instance (full range)
   logic          start = 1'b0;
   logic [AW-1:0] rf_raddr;
   logic [DW-1:0] rf_rdata;
   logic          rf_hold;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;
   logic [1:0]    dbg_state;

   // single-register instance
   logic          start2 = 1'b0;
   logic [AW-1:0] rf_raddr2;
   logic [DW-1:0] rf_rdata2;
   logic          rf_hold2;
   logic          out_valid2;
   logic          out_ready2 = 1'b1;
   logic [AW-1:0] out_addr2;
   logic [DW-1:0] out_data2;
   logic          busy2;
   logic          done2;
   logic [1:0]    dbg_state2;

   // Register file model: combinational read, and x0 always reads 0.
   logic [DW-1:0] rf [32];
   assign rf_rdata  = rf[rf_raddr];
   assign rf_rdata2 = rf[rf_raddr2];

   regfile_dump #(.ADDR_W(AW), .DATA_W(DW), .FIRST(0), .LAST(31)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_hold(rf_hold),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   regfile_dump #(.ADDR_W(AW), .DATA_W(DW), .FIRST(5), .LAST(5)) dut_one (
      .clk(clk), .rst(rst), .start(start2),
      .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2), .rf_hold(rf_hold2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .out_addr(out_addr2), .out_data(out_data2),
      .busy(busy2), .done(done2), .dbg_state(dbg_state2)
   );

   // scoreboard
   logic [BW-1:0] exp_q[$];
   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic preload_fixed();
      rf[0] = '0;
      for (int i = 1; i < 32; i++) rf[i] = 32'h100 + DW'(i);
   endtask

   task automatic preload_random();
      rf[0] = '0;
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_busy"},  64'(busy),      64'(0));
      check({tag, "_hold"},  64'(rf_hold),   64'(0));
      check({tag, "_done"},  64'(done),      64'(0));
      check({tag, "_addr"},  64'(out_addr),  64'(0));
      check({tag, "_data"},  64'(out_data),  64'(0));
      check({tag, "_raddr"}, 64'(rf_raddr),  64'(0));
   endtask

   // Driver: one full dump on the main instance, compared per cycle.
   // Timing model: the first beat is valid in cycle 2 after start. Each next
   // beat is valid 2 cycles after the previous acceptance. done comes 1 cycle
   // after the last acceptance, and busy lasts from cycle 1 through done.
   // ready_mode: 0 = always ready, 1 = three stall cycles on beat 7,
   //             2 = random ready.
   // restart_addr / rst_addr / poke_addr / hold_wr: -1 or 0 disables.
   task automatic run_dump(input int ready_mode, input int restart_addr,
                           input int rst_addr, input int poke_addr, input bit hold_wr);
      int cyc, valid_from, done_cyc, stalls, stall_used, obs_done;
      bit rdy, exp_valid, poked, pend_wr, finished;
      logic [BW-1:0] front;
      logic [AW-1:0] exp_raddr;
      exp_q.delete();
      for (int a = 0; a < 32; a++) exp_q.push_back({AW'(a), rf[a]});
      valid_from = 2; done_cyc = 1_000_000; stalls = 0; stall_used = 0;
      obs_done = -1; poked = 1'b0; pend_wr = hold_wr; finished = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      while (!finished) begin
         front = (exp_q.size() > 0) ? exp_q[0] : '0;
         exp_valid = (exp_q.size() > 0) && (cyc >= valid_from);
         rdy = 1'b1;
         if (ready_mode == 1 && exp_valid && front[BW-1:DW] == AW'(7) && stall_used < 3) rdy = 1'b0;
         if (ready_mode == 2) rdy = ($urandom_range(0, 2) != 0);
         out_ready = rdy;
         start = exp_valid && (int'(front[BW-1:DW]) == restart_addr);
         rst = !(exp_valid && int'(front[BW-1:DW]) == rst_addr);
         if (!poked && exp_valid && int'(front[BW-1:DW]) == poke_addr) begin
            rf[poke_addr] = ~rf[poke_addr];
            poked = 1'b1;
         end
         // core write to x3 that waits for rf_hold to drop
         if (pend_wr && cyc == 5 && !rf_hold) begin
            rf[3] = 32'hDEAD_0003;
            pend_wr = 1'b0;
         end
         @(negedge clk);
         exp_raddr = (exp_q.size() > 0 && cyc == valid_from - 1) ? front[BW-1:DW] : '0;
         check("busy",      64'(busy),      64'(cyc <= done_cyc));
         check("rf_hold",   64'(rf_hold),   64'(cyc <= done_cyc));
         check("out_valid", 64'(out_valid), 64'(exp_valid));
         check("done",      64'(done),      64'(cyc == done_cyc));
         check("rf_raddr",  64'(rf_raddr),  64'(exp_raddr));
         if (exp_valid) check("beat", 64'({out_addr, out_data}), 64'(front));
         if (done && obs_done < 0) obs_done = cyc;
         if (!rst) begin
            @(posedge clk); #1 rst = 1'b1; start = 1'b0;
            @(negedge clk);
            check_all_zero("reset_mid");
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               check("reset_no_done", 64'(done), 64'(0));
               check("reset_idle",    64'(busy), 64'(0));
            end
            return;
         end
         if (cyc == done_cyc) begin
            finished = 1'b1;
         end else begin
            if (exp_valid && rdy) begin
               exp_q.pop_front();
               valid_from = cyc + 2;
               if (exp_q.size() == 0) done_cyc = cyc + 1;
            end else if (exp_valid) begin
               stalls++;
               stall_used++;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 400) begin
               check("cycle_budget", 64'(done), 64'(1));
               finished = 1'b1;
            end
         end
      end
      check("done_time", 64'(obs_done), 64'(2 * 32 + 1 + stalls));
      @(posedge clk); #1 start = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("idle_busy",  64'(busy),      64'(0));
      check("idle_done",  64'(done),      64'(0));
      check("idle_valid", 64'(out_valid), 64'(0));
      if (pend_wr) rf[3] = 32'hDEAD_0003;
   endtask

   initial begin
      // reset
      preload_fixed();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      check("reset_busy2",  64'(busy2),      64'(0));
      check("reset_valid2", 64'(out_valid2), 64'(0));
      @(posedge clk); #1 rst = 1'b1;

      // fixed preload, always ready
      preload_fixed();
      run_dump(0, -1, -1, -1, 1'b0);

      // back-pressure on beat 7
      preload_fixed();
      run_dump(1, -1, -1, -1, 1'b0);

      // second start during SEND of beat 10 is ignored
      preload_fixed();
      run_dump(0, 10, -1, -1, 1'b0);

      // reset during beat 12, then a clean dump
      preload_fixed();
      run_dump(0, -1, 12, -1, 1'b0);
      run_dump(0, -1, -1, -1, 1'b0);

      // core write to x3 deferred by rf_hold: dump shows the pre-start value
      preload_random();
      run_dump(0, -1, -1, -1, 1'b1);

      // core ignores hold and writes x20 after capture
      preload_random();
      run_dump(0, -1, -1, 20, 1'b0);

      // random data with random back-pressure
      for (int r = 0; r < 3; r++) begin
         preload_random();
         run_dump(2, -1, -1, -1, 1'b0);
      end

      // single-register range: one beat (5, x5), done 3 cycles after start
      rf[5] = $urandom;
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      @(negedge clk);
      check("one_c1_busy",  64'(busy2),      64'(1));
      check("one_c1_raddr", 64'(rf_raddr2),  64'(5));
      check("one_c1_valid", 64'(out_valid2), 64'(0));
      @(negedge clk);
      check("one_c2_valid", 64'(out_valid2), 64'(1));
      check("one_c2_beat",  64'({out_addr2, out_data2}), 64'({AW'(5), rf[5]}));
      @(negedge clk);
      check("one_c3_done",  64'(done2),      64'(1));
      check("one_c3_valid", 64'(out_valid2), 64'(0));
      check("one_c3_hold",  64'(rf_hold2),   64'(1));
      @(negedge clk);
      check("one_c4_busy",  64'(busy2),      64'(0));
      check("one_c4_done",  64'(done2),      64'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
